bank_mem_resp: RTL and testbench

- Responder end of the cache-to-memory interface: a four-bank, word-interleaved, pipelined main-memory model that services the cache controller's fill and writeback traffic.
- Accepts one read or write request per cycle as long as the target bank is idle.
- Returns read data a fixed latency after acceptance.
- Reports per-bank busy, stall and protocol errors back to the initiator.

---
 rtl/bank_mem_pkg.sv | 21 ++
 rtl/bank_mem_resp_if.sv | 26 ++
 rtl/bank_mem_resp_mem_bank.sv | 58 +++++
 rtl/bank_mem_resp.sv | 96 +++++++++
 tb/tb_bank_mem_resp.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bank_mem_pkg.sv
// Shared constants and the read-return pipeline entry for the four-bank memory responder.
package bank_mem_pkg;

  localparam int NUM_BANKS       = 4;
  localparam int BANK_IDX_W      = 2;
  localparam int DEF_BANK_CYCLES = 4;
  localparam int DEF_RD_LATENCY  = 2;
  // Widest row a 16-bit byte address can carry (addr[15:3]).
  localparam int ROW_W           = 13;

  typedef struct packed {
    logic                  valid;
    logic [BANK_IDX_W-1:0] bank;
    logic [ROW_W-1:0]      row;
  } rd_pipe_entry_t;

  function automatic logic [BANK_IDX_W-1:0] addr_bank(input logic [15:0] addr);
    return addr[2:1];
  endfunction

endpackage

// File: rtl/bank_mem_resp_if.sv
// Cache-to-memory bus between the cache controller (master) and the banked memory (slave).
interface bank_mem_resp_if;

  // A request (rd or wr) is taken on a clock edge only when stall is low in that cycle;
  // while stall is high the master holds addr/data_in/rd/wr unchanged and retries.
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, rd_valid, stall, busy, err
  );

endinterface

// File: rtl/bank_mem_resp_mem_bank.sv
// One memory bank: word storage, synchronous write, registered read and a busy down-counter.
module mem_bank
  import bank_mem_pkg::*;
#(
  parameter int ROW_BITS    = ROW_W,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                we,
  input  logic [ROW_BITS-1:0] wrow,
  input  logic [15:0]         wdata,
  input  logic                rd_en,
  input  logic [ROW_BITS-1:0] rrow,
  output logic [15:0]         rdata,
  output logic                busy
);

  localparam int CNT_W = $clog2(BANK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      mem_q [2**ROW_BITS];

  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d = CNT_W'(BANK_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (rd_en) begin
      rdata_d = mem_q[rrow];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage and the read register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (accept && we) begin
      mem_q[wrow] <= wdata;
    end
  end

  assign busy  = (cnt_q != '0);
  assign rdata = rdata_q;

endmodule

// File: rtl/bank_mem_resp.sv
// Four-bank word-interleaved memory responder: decode, accept/stall/err, read-return pipeline.
// Optional macro BANK_STALL_ERR_EN: a legal request to a busy bank also pulses err.
module bank_mem_resp
  import bank_mem_pkg::*;
#(
  parameter int ROW_BITS    = ROW_W,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES,
  parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  bank_mem_resp_if.slave  bus
);

  logic                  req, legal, accept;
  logic [BANK_IDX_W-1:0] bank;
  logic [ROW_BITS-1:0]   row;
  logic [NUM_BANKS-1:0]  busy;
  logic [15:0]           rdata [NUM_BANKS];

  rd_pipe_entry_t        pipe_q [RD_LATENCY];
  rd_pipe_entry_t        pipe_d [RD_LATENCY];
  rd_pipe_entry_t        out_entry;
  logic                  rd_valid_q, rd_valid_d;
  logic [BANK_IDX_W-1:0] rd_bank_q, rd_bank_d;
  logic                  err_q, err_d;

  assign req    = bus.rd | bus.wr;
  assign legal  = (bus.rd ^ bus.wr) & ~bus.addr[0];
  assign bank   = addr_bank(bus.addr);
  assign row    = bus.addr[ROW_BITS+2:3];
  assign accept = legal & ~busy[bank];

  // The last pipeline stage drives the bank read port; rd_valid follows one edge later.
  assign out_entry = pipe_q[RD_LATENCY-1];

  always_comb begin
    pipe_d = pipe_q;
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      pipe_d[i] = pipe_q[i-1];
    end
    pipe_d[0].valid = accept & bus.rd;
    pipe_d[0].bank  = bank;
    pipe_d[0].row   = ROW_W'(row);

    rd_valid_d = out_entry.valid;
    rd_bank_d  = out_entry.bank;

`ifdef BANK_STALL_ERR_EN
    err_d = req & ~accept;
`else
    err_d = req & ~legal;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      pipe_q     <= pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
      err_q      <= err_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .ROW_BITS    (ROW_BITS),
      .BANK_CYCLES (BANK_CYCLES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .accept (accept && bank == BANK_IDX_W'(b)),
      .we     (bus.wr),
      .wrow   (row),
      .wdata  (bus.data_in),
      .rd_en  (out_entry.valid && out_entry.bank == BANK_IDX_W'(b)),
      .rrow   (out_entry.row[ROW_BITS-1:0]),
      .rdata  (rdata[b]),
      .busy   (busy[b])
    );
  end

  assign bus.stall    = req & ~accept;
  assign bus.busy     = busy;
  assign bus.err      = err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.data_out = rd_valid_q ? rdata[rd_bank_q] : 16'h0000;

endmodule

// File: tb/tb_bank_mem_resp.sv
// Directed bench for bank_mem_resp: same-bank RAW, interleaving, conflicts, illegal requests, reset, row extremes.
module tb_bank_mem_resp;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];

`ifdef BANK_STALL_ERR_EN
  localparam logic STALL_ERR = 1'b1;
`else
  localparam logic STALL_ERR = 1'b0;
`endif

  bank_mem_resp_if bus();

  bank_mem_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write to an idle bank, then wait until that bank is idle again.
  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b0, 1'b1, a, d);
    chk("wr_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) tick();
  endtask

  // Read from an idle bank and check the return two edges after accept.
  task automatic rd_word(input logic [15:0] a, input logic [15:0] exp, input string tag);
    drive(1'b1, 1'b0, a, 16'h0000);
    chk({tag, "_stall"}, {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk({tag, "_early"}, {15'b0, bus.rd_valid}, 16'h0000);
    tick();
    tick();
    chk({tag, "_valid"}, {15'b0, bus.rd_valid}, 16'h0001);
    chk({tag, "_data"}, bus.data_out, exp);
    tick();
    chk({tag, "_vdrop"}, {15'b0, bus.rd_valid}, 16'h0000);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) tick();
    chk("rst_busy", {12'b0, bus.busy}, 16'h0000);
    chk("rst_rd_valid", {15'b0, bus.rd_valid}, 16'h0000);
    chk("rst_data_out", bus.data_out, 16'h0000);
    chk("rst_err", {15'b0, bus.err}, 16'h0000);
    rst = 1'b0;
    tick();

    // Write then read, same bank 0: read issued early stalls for three cycles
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("raw_wr_stall", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("raw_busy", {12'b0, bus.busy}, 16'h0001);
    chk("raw_stall1", {15'b0, bus.stall}, 16'h0001);
    tick();
    chk("raw_stall2", {15'b0, bus.stall}, 16'h0001);
    chk("raw_err_busy", {15'b0, bus.err}, {15'b0, STALL_ERR});
    tick();
    chk("raw_stall3", {15'b0, bus.stall}, 16'h0001);
    tick();
    chk("raw_busy_drop", {12'b0, bus.busy}, 16'h0000);
    chk("raw_accept", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("raw_err_clear", {15'b0, bus.err}, 16'h0000);
    chk("raw_rv0", {15'b0, bus.rd_valid}, 16'h0000);
    tick();
    chk("raw_rv1", {15'b0, bus.rd_valid}, 16'h0000);
    tick();
    chk("raw_rv2", {15'b0, bus.rd_valid}, 16'h0001);
    chk("raw_data", bus.data_out, 16'hBEEF);
    tick();
    chk("raw_rv3", {15'b0, bus.rd_valid}, 16'h0000);
    chk("raw_data_zero", bus.data_out, 16'h0000);

    // Interleaved reads across all four banks on consecutive cycles
    wr_word(16'h0000, 16'h1111);
    wr_word(16'h0002, 16'h2222);
    wr_word(16'h0004, 16'h3333);
    wr_word(16'h0006, 16'h4444);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("il_stall0", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("il_stall1", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0004, 16'h0000);
    chk("il_stall2", {15'b0, bus.stall}, 16'h0000);
    tick();
    chk("il_busy3", {12'b0, bus.busy}, 16'h0007);
    chk("il_rv_a", {15'b0, bus.rd_valid}, 16'h0001);
    chk("il_data_a", bus.data_out, exp_q.pop_front());
    drive(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("il_stall3", {15'b0, bus.stall}, 16'h0000);
    tick();
    chk("il_busy4", {12'b0, bus.busy}, 16'h000E);
    chk("il_rv_b", {15'b0, bus.rd_valid}, 16'h0001);
    chk("il_data_b", bus.data_out, exp_q.pop_front());
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk("il_rv_c", {15'b0, bus.rd_valid}, 16'h0001);
    chk("il_data_c", bus.data_out, exp_q.pop_front());
    tick();
    chk("il_rv_d", {15'b0, bus.rd_valid}, 16'h0001);
    chk("il_data_d", bus.data_out, exp_q.pop_front());
    tick();
    chk("il_rv_end", {15'b0, bus.rd_valid}, 16'h0000);

    // Bank conflict: two reads to bank 0 on consecutive cycles
    wr_word(16'h0008, 16'h5555);
    drive(1'b1, 1'b0, 16'h0008, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("bc_stall1", {15'b0, bus.stall}, 16'h0001);
    tick();
    chk("bc_stall2", {15'b0, bus.stall}, 16'h0001);
    chk("bc_err", {15'b0, bus.err}, {15'b0, STALL_ERR});
    tick();
    chk("bc_stall3", {15'b0, bus.stall}, 16'h0001);
    chk("bc_rv_first", {15'b0, bus.rd_valid}, 16'h0001);
    chk("bc_data_first", bus.data_out, 16'h5555);
    tick();
    chk("bc_accept4", {15'b0, bus.stall}, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("bc_err_clear", {15'b0, bus.err}, 16'h0000);
    tick();
    tick();
    chk("bc_rv_second", {15'b0, bus.rd_valid}, 16'h0001);
    chk("bc_data_second", bus.data_out, 16'h1111);
    tick();

    // Illegal requests: rd&wr, then misaligned read
    wr_word(16'h0020, 16'h6666);
    drive(1'b1, 1'b1, 16'h0020, 16'hDEAD);
    chk("ill_both_stall", {15'b0, bus.stall}, 16'h0001);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("ill_both_err", {15'b0, bus.err}, 16'h0001);
    chk("ill_both_busy", {12'b0, bus.busy}, 16'h0000);
    tick();
    chk("ill_both_err_end", {15'b0, bus.err}, 16'h0000);
    chk("ill_both_rv", {15'b0, bus.rd_valid}, 16'h0000);
    drive(1'b1, 1'b0, 16'h0021, 16'h0000);
    chk("ill_odd_stall", {15'b0, bus.stall}, 16'h0001);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("ill_odd_err", {15'b0, bus.err}, 16'h0001);
    chk("ill_odd_busy", {12'b0, bus.busy}, 16'h0000);
    tick();
    chk("ill_odd_err_end", {15'b0, bus.err}, 16'h0000);
    chk("ill_odd_rv1", {15'b0, bus.rd_valid}, 16'h0000);
    tick();
    chk("ill_odd_rv2", {15'b0, bus.rd_valid}, 16'h0000);
    rd_word(16'h0020, 16'h6666, "ill_keep");

    // Reset while a read to bank 2 is in flight
    drive(1'b1, 1'b0, 16'h0004, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    tick();
    chk("mr_busy", {12'b0, bus.busy}, 16'h0000);
    chk("mr_rv", {15'b0, bus.rd_valid}, 16'h0000);
    chk("mr_data", bus.data_out, 16'h0000);
    rst = 1'b0;
    tick();
    chk("mr_rv_late1", {15'b0, bus.rd_valid}, 16'h0000);
    tick();
    chk("mr_rv_late2", {15'b0, bus.rd_valid}, 16'h0000);
    chk("mr_data_late", bus.data_out, 16'h0000);
    rd_word(16'h0004, 16'h3333, "mr_storage");

    // Row extremes of bank 3 and overwrite of row 0 of bank 0
    wr_word(16'h0000, 16'h1234);
    rd_word(16'h0000, 16'h1234, "wrap_row0");
    wr_word(16'hFFFE, 16'h7E7E);
    wr_word(16'h0006, 16'h0606);
    rd_word(16'hFFFE, 16'h7E7E, "b3_row8191");
    rd_word(16'h0006, 16'h0606, "b3_row0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
